// File: rtl/r16_bu_scheduler_if.sv
// Issue/write-back bundle between the radix-16 butterfly scheduler and its host.
// R16_SCHED_PERF_EN adds the stall_cnt observation signal.
interface r16_bu_scheduler_if #(
  parameter int GROUP_AW = 4,
  parameter int STAGE_W  = 4
);
  logic                        start;
  logic [GROUP_AW:0]           num_groups;
  logic [STAGE_W-1:0]          stage_idx;
  logic                        stall;
  logic                        busy;
  logic                        done;
  logic                        rd_en;
  logic [GROUP_AW-1:0]         rd_grp;
  logic [STAGE_W+GROUP_AW-1:0] tw_addr;
  logic                        wr_en;
  logic [GROUP_AW-1:0]         wr_grp;
`ifdef R16_SCHED_PERF_EN
  logic [15:0]                 stall_cnt;

  modport master (
    output start, num_groups, stage_idx, stall,
    input  busy, done, rd_en, rd_grp, tw_addr, wr_en, wr_grp, stall_cnt
  );
  modport slave (
    input  start, num_groups, stage_idx, stall,
    output busy, done, rd_en, rd_grp, tw_addr, wr_en, wr_grp, stall_cnt
  );
`else
  modport master (
    output start, num_groups, stage_idx, stall,
    input  busy, done, rd_en, rd_grp, tw_addr, wr_en, wr_grp
  );
  modport slave (
    input  start, num_groups, stage_idx, stall,
    output busy, done, rd_en, rd_grp, tw_addr, wr_en, wr_grp
  );
`endif
endinterface

// File: rtl/r16_bu_scheduler.sv
// Sequences one NTT pass through the radix-16 butterfly pipe: issues groups, tracks them
// through the read + butterfly latency, strobes write-back. R16_SCHED_PERF_EN adds stall_cnt.
//
// state  | meaning
// IDLE   | waiting for start; N and stage latched on accept
// ISSUE  | one group read per non-stalled cycle
// DRAIN  | all groups issued, waiting for in-flight results
// DONE   | one-cycle done pulse, busy still high
module r16_bu_scheduler #(
  parameter int GROUP_AW   = 4,
  parameter int STAGE_W    = 4,
  parameter int BU_LATENCY = 20,
  parameter int MEM_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  r16_bu_scheduler_if.slave    bus
);

  localparam int TAG_LAT = MEM_LAT + BU_LATENCY;
  localparam int PIPE_D  = TAG_LAT - 1;
  localparam int IFL_W   = GROUP_AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [GROUP_AW:0]   num_q, num_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [GROUP_AW-1:0] cnt_q, cnt_d;
  logic [IFL_W-1:0]    ifl_q, ifl_d;
  logic [PIPE_D-1:0]   tag_vld_q;
  logic [GROUP_AW-1:0] tag_grp_q [PIPE_D];
  logic                wr_en_q;
  logic [GROUP_AW-1:0] wr_grp_q;
  logic                rd_en;

  assign rd_en = (state_q == S_ISSUE) && !bus.stall;

  always_comb begin
    ifl_d = ifl_q;
    case ({rd_en, wr_en_q})
      2'b10:   ifl_d = ifl_q + IFL_W'(1);
      2'b01:   ifl_d = ifl_q - IFL_W'(1);
      default: ifl_d = ifl_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_d   = bus.num_groups;
          stage_d = bus.stage_idx;
          cnt_d   = '0;
          state_d = (bus.num_groups == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rd_en) begin
          // counter wraps to 0 after the last group of a full 2^GROUP_AW pass
          cnt_d = cnt_q + GROUP_AW'(1);
          if ({1'b0, cnt_q} == num_q - (GROUP_AW+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // look at next-cycle count so done follows the last wr_en directly
        if (ifl_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      ifl_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      ifl_q   <= ifl_d;
    end
  end

  // tag pipe plus the wr_en output register together span MEM_LAT+BU_LATENCY cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < PIPE_D; i++) tag_grp_q[i] <= '0;
      wr_en_q   <= 1'b0;
      wr_grp_q  <= '0;
    end else begin
      tag_vld_q    <= {tag_vld_q[PIPE_D-2:0], rd_en};
      tag_grp_q[0] <= cnt_q;
      for (int i = 1; i < PIPE_D; i++) tag_grp_q[i] <= tag_grp_q[i-1];
      wr_en_q      <= tag_vld_q[PIPE_D-1];
      wr_grp_q     <= tag_grp_q[PIPE_D-1];
    end
  end

`ifdef R16_SCHED_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        start_acc;

  assign start_acc = (state_q == S_IDLE) && bus.start;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc)
      stall_cnt_d = '0;
    else if ((state_q == S_ISSUE) && bus.stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.rd_en   = rd_en;
  assign bus.rd_grp  = cnt_q;
  assign bus.tw_addr = {stage_q, cnt_q};
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_grp  = wr_grp_q;

endmodule

// File: tb/tb_r16_bu_scheduler.sv
// Scoreboard bench for r16_bu_scheduler: drivers push expected read/write/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_r16_bu_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] grp;
    logic [7:0] tw;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  ev_t mon_e;
  int  mon_c;

  r16_bu_scheduler_if #(.GROUP_AW(4), .STAGE_W(4)) sif ();

  r16_bu_scheduler #(
    .GROUP_AW(4), .STAGE_W(4), .BU_LATENCY(20), .MEM_LAT(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s @cyc %0d: got event expected none", name, cyc);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (sif.rd_en) begin
        if (rd_q.size() == 0) unexpected("rd_en");
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_cyc", cyc, mon_e.cyc);
          chk("rd_grp", sif.rd_grp, mon_e.grp);
          chk("tw_addr", sif.tw_addr, mon_e.tw);
        end
      end
      if (sif.wr_en) begin
        if (wr_q.size() == 0) unexpected("wr_en");
        else begin
          mon_e = wr_q.pop_front();
          chk("wr_cyc", cyc, mon_e.cyc);
          chk("wr_grp", sif.wr_grp, mon_e.grp);
        end
      end
      if (sif.done) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          mon_c = done_q.pop_front();
          chk("done_cyc", cyc, mon_c);
          chk("busy_at_done", sif.busy, 1);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_rd(input int c, input int g, input int stage);
    ev_t e;
    e.cyc = c;
    e.grp = g[3:0];
    e.tw  = {stage[3:0], g[3:0]};
    rd_q.push_back(e);
  endtask

  task automatic exp_wr(input int c, input int g);
    ev_t e;
    e.cyc = c;
    e.grp = g[3:0];
    e.tw  = 8'h00;
    wr_q.push_back(e);
  endtask

  task automatic issue_start(input int n, input int stage);
    sif.num_groups = n[4:0];
    sif.stage_idx  = stage[3:0];
    sif.start      = 1'b1;
    tick();
    sif.start      = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0 || sif.busy) && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s: timeout, pending rd=%0d wr=%0d done=%0d busy=%0b",
               name, rd_q.size(), wr_q.size(), done_q.size(), sif.busy);
    end
    tick(3);
  endtask

  initial begin
    int t0;
    sif.start      = 1'b0;
    sif.num_groups = '0;
    sif.stage_idx  = '0;
    sif.stall      = 1'b0;
    tick(3);
    chk("rst_busy", sif.busy, 0);
    chk("rst_done", sif.done, 0);
    chk("rst_rd_en", sif.rd_en, 0);
    chk("rst_wr_en", sif.wr_en, 0);
    chk("rst_tw_addr", sif.tw_addr, 0);
    chk("rst_wr_grp", sif.wr_grp, 0);
    rst = 1'b1;
    tick(2);

    // N=1
    t0 = cyc;
    exp_rd(t0 + 1, 0, 2);
    exp_wr(t0 + 22, 0);
    done_q.push_back(t0 + 23);
    issue_start(1, 2);
    chk("busy_after_start", sif.busy, 1);
    wait_idle("n1", 60);
`ifdef R16_SCHED_PERF_EN
    chk("stall_cnt_n1", sif.stall_cnt, 0);
`endif

    // N=4, stage 3
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      exp_rd(t0 + 1 + i, i, 3);
      exp_wr(t0 + 22 + i, i);
    end
    done_q.push_back(t0 + 26);
    issue_start(4, 3);
    wait_idle("n4", 60);

    // N=4 with stall in cycles 2-3
    t0 = cyc;
    exp_rd(t0 + 1, 0, 1);
    exp_rd(t0 + 4, 1, 1);
    exp_rd(t0 + 5, 2, 1);
    exp_rd(t0 + 6, 3, 1);
    exp_wr(t0 + 22, 0);
    exp_wr(t0 + 25, 1);
    exp_wr(t0 + 26, 2);
    exp_wr(t0 + 27, 3);
    done_q.push_back(t0 + 28);
    issue_start(4, 1);
    tick();
    sif.stall = 1'b1;
    tick(2);
    sif.stall = 1'b0;
    wait_idle("stall", 60);
`ifdef R16_SCHED_PERF_EN
    chk("stall_cnt", sif.stall_cnt, 2);
`endif

    // N=0, with stall held high to show it has no effect outside ISSUE
    sif.stall = 1'b1;
    t0 = cyc;
    done_q.push_back(t0 + 1);
    issue_start(0, 6);
    chk("n0_busy_c1", sif.busy, 1);
    tick();
    chk("n0_busy_c2", sif.busy, 0);
    sif.stall = 1'b0;
    wait_idle("n0", 20);

    // N=16, second start at cycle 5 ignored
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      exp_rd(t0 + 1 + i, i, 5);
      exp_wr(t0 + 22 + i, i);
    end
    done_q.push_back(t0 + 38);
    issue_start(16, 5);
    tick(4);
    sif.num_groups = 5'd2;
    sif.stage_idx  = 4'd9;
    sif.start      = 1'b1;
    tick();
    sif.start      = 1'b0;
    wait_idle("n16", 80);
    chk("cnt_wrap", sif.rd_grp, 0);
    chk("tw_stage_held", sif.tw_addr, 8'h50);

    // N=8 with reset mid-pass, then clean N=1 pass
    t0 = cyc;
    for (int i = 0; i < 8; i++) exp_rd(t0 + 1 + i, i, 7);
    issue_start(8, 7);
    tick(9);
    rst = 1'b0;
    #1;
    chk("midrst_busy", sif.busy, 0);
    chk("midrst_rd_en", sif.rd_en, 0);
    chk("midrst_wr_en", sif.wr_en, 0);
    chk("midrst_done", sif.done, 0);
    chk("midrst_tw_addr", sif.tw_addr, 0);
    chk("midrst_rd_q_empty", rd_q.size(), 0);
    tick();
    rst = 1'b1;
    tick();
    exp_rd(t0 + 13, 0, 4);
    exp_wr(t0 + 34, 0);
    done_q.push_back(t0 + 35);
    issue_start(1, 4);
    wait_idle("after_rst", 60);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/r16_bu_scheduler.md
Name: r16_bu_scheduler

Overview:
- Sequences one NTT pass through the pipelined radix-16 butterfly unit (R16_BU).
- Issues N groups of 16 points from the data buffer, one group per cycle, and generates the matching twiddle-bank address.
- Tracks each group through the fixed butterfly latency and raises a write-back strobe with the group index when the result leaves the pipe.
- Pulses done when the last result has been written back.

Parameters:
- GROUP_AW, 4, width of the group index; up to 2^GROUP_AW groups per pass.
- STAGE_W, 4, width of the stage/twiddle-bank select.
- BU_LATENCY, 20, butterfly input-to-output latency in cycles.
- MEM_LAT, 1, data-buffer read latency in cycles; rd_en to BU input.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a pass; sampled only in IDLE
- num_groups  in  GROUP_AW+1  groups in this pass; latched at start; 0 is legal
- stage_idx  in  STAGE_W  stage number; latched at start
- stall  in  1  suppress issue this cycle; groups already in flight are unaffected
- busy  out  1  high from the start-accept edge until done
- done  out  1  one-cycle pulse at pass end
- rd_en  out  1  data-buffer read and twiddle fetch for rd_grp
- rd_grp  out  GROUP_AW  group being read
- tw_addr  out  STAGE_W+GROUP_AW  twiddle address {stage_lat, rd_grp}
- wr_en  out  1  BU result valid; write back wr_grp
- wr_grp  out  GROUP_AW  group index of the current result

Behaviour:
- Reset (rst=0, async) values: state IDLE, all outputs 0, group counter 0, tag pipe cleared, in-flight count 0.
- States are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - start=1 with num_groups>0: latch N and stage, go to ISSUE, busy=1 from next cycle.
  - start=1 with num_groups=0: go to DONE.
- ISSUE:
  - rd_en = !stall, combinational from state; rd_grp = group counter register.
  - Each rd_en cycle increments the counter.
  - rd_en with counter==N-1: go to DRAIN.
- DRAIN: no reads. Once in-flight count is 0, go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- Tag pipe: a shift register of depth MEM_LAT+BU_LATENCY carrying {valid, group}.
  - A read at cycle k produces wr_en=1 and wr_grp=that group at cycle k+MEM_LAT+BU_LATENCY (k+21 at defaults).
  - wr_en is registered, from the last tag stage.
- In-flight counter: +1 on rd_en, -1 on wr_en; both in the same cycle means unchanged.
- The last wr_en cycle is followed immediately by the done cycle.
- start while busy is ignored; latched N and stage are not changed.
- stall outside ISSUE has no effect. A stall gap in ISSUE leaves the same gap in the wr_en stream.
- num_groups = 2^GROUP_AW is legal; the counter wraps to 0 only after the last issue.
- tw_addr is valid only while rd_en=1. It holds {stage_lat, rd_grp} otherwise and is don't-care.
- Reset mid-pass:
  - All in-flight tags are discarded; no wr_en after rst is released.
  - The next start begins a clean pass.

Optional Feature:
- Macro: R16_SCHED_PERF_EN.
- When defined:
  - Adds output stall_cnt [15:0], which counts cycles in ISSUE with stall=1.
  - Cleared when start is accepted; saturates at 16'hFFFF.
  - Holds its value after done until the next start.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- N=1, start at cycle 0, stall=0 -> rd_en only at cycle 1 (rd_grp=0); wr_en only at cycle 22 (wr_grp=0); done at cycle 23; busy high cycles 1-23.
- N=4, stage_idx=3 -> rd_en cycles 1-4 with rd_grp 0-3 and tw_addr 8'h30-8'h33; wr_en cycles 22-25 with wr_grp 0-3; done at cycle 26.
- N=4, stall=1 in cycles 2-3 -> rd_en cycles 1,4,5,6; wr_en cycles 22,25,26,27; done at cycle 28; stall_cnt=2 with PERF_EN.
- N=0 -> no rd_en or wr_en ever; done and busy high at cycle 1 only.
- N=16 (max), second start at cycle 5 with N=2 -> second start ignored; 16 reads (grp 0-15, counter wraps to 0); wr_en cycles 22-37; done at cycle 38.
- N=8, rst low at cycle 10 for one cycle -> all outputs 0 immediately; no wr_en through cycle 40; new start with N=1 at cycle 12 -> wr_en at cycle 34, done at cycle 35.
